// File: rtl/picorv32_mem_responder_pkg.sv
// Shared types and constants for the picorv32 memory responder.
package picorv32_mem_responder_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, CONS, RESP} state_t;
   typedef enum logic [1:0] {REG_RAM, REG_CONS, REG_NONE} region_t;

   localparam logic [31:0] RDATA_UNMAPPED = 32'h0;

   // Word-granular decode; the RAM window test relies on 32-bit wrap so
   // addresses below base land far above the window.
   function automatic region_t decode(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] cons, input logic [31:0] span);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      if (word == {cons[31:2], 2'b00}) return REG_CONS;
      if ((word - base) < span)        return REG_RAM;
      return REG_NONE;
   endfunction

endpackage

// File: rtl/picorv32_mem_responder_if.sv
// picorv32 native memory bus: the core is master, the responder is slave.
interface picorv32_mem_responder_if;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                   input  mem_ready, mem_rdata);
   modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                   output mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_resp_ram.sv
// Single-port word RAM, synchronous read, per-byte write enables.
module picorv32_resp_ram #(
   parameter int MEM_WORDS = 4096
) (
   input  logic                         clk,
   input  logic                         en,
   input  logic [3:0]                   we,
   input  logic [$clog2(MEM_WORDS)-1:0] addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/picorv32_mem_responder.sv
// Memory + console slave for picorv32: on-chip RAM with wait states,
// backpressured console byte port and sticky first-error capture.
module picorv32_mem_responder
   import picorv32_mem_responder_pkg::*;
#(
   parameter int          MEM_WORDS    = 4096,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
   parameter int          WAIT_STATES  = 0,
   parameter bit          RDATA_HOLD   = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   picorv32_mem_responder_if.slave   mem,
   output logic                      cons_valid,
   output logic [7:0]                cons_data,
   input  logic                      cons_ready,
   output logic                      err,
   output logic [31:0]               err_addr
);

   localparam int          IDX_W = $clog2(MEM_WORDS);
   localparam logic [31:0] SPAN  = 32'(MEM_WORDS * 4);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   state_t      state, state_d;
   region_t     region_in, region_q;
   logic [3:0]  cnt;
   logic [31:0] addr_q, wdata_q, off, ram_q, rd_val, rdata_hold;
   logic [3:0]  wstrb_q;
   logic        accept, abort, ram_go, is_read;

   assign region_in = decode(mem.mem_addr, BASE_ADDR, CONSOLE_ADDR, SPAN);

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      abort   = 1'b0;
      ram_go  = 1'b0;
      case (state)
         IDLE: if (mem.mem_valid) begin
            accept  = 1'b1;
            state_d = (region_in == REG_CONS && mem.mem_wstrb != 4'h0) ? CONS : WAIT;
         end
         WAIT: if (!mem.mem_valid) begin
            abort   = 1'b1;
            state_d = IDLE;
         end else if (cnt == 4'd0) begin
            ram_go  = 1'b1;
            state_d = RESP;
         end
         CONS: if (!mem.mem_valid) begin
            abort   = 1'b1;
            state_d = IDLE;
         end else if (cons_ready) begin
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= 4'd0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         region_q   <= REG_NONE;
         err        <= 1'b0;
         err_addr   <= 32'h0;
         rdata_hold <= 32'h0;
      end else begin
         if (accept) begin
            addr_q   <= mem.mem_addr;
            wdata_q  <= mem.mem_wdata;
            wstrb_q  <= mem.mem_wstrb;
            region_q <= region_in;
            cnt      <= WS;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         // Only the first fault is recorded so bring-up sees the root cause.
         if (!err && ((accept && region_in == REG_NONE) || abort)) begin
            err      <= 1'b1;
            err_addr <= abort ? addr_q : mem.mem_addr;
         end
         if (state == RESP && is_read) rdata_hold <= rd_val;
      end
   end

   assign off = addr_q - BASE_ADDR;

   picorv32_resp_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
      .clk   (clk),
      .en    (ram_go && region_q == REG_RAM),
      .we    (wstrb_q),
      .addr  (off[IDX_W+1:2]),
      .wdata (wdata_q),
      .rdata (ram_q)
   );

   assign is_read = (wstrb_q == 4'h0);
   assign rd_val  = (region_q == REG_RAM) ? ram_q : RDATA_UNMAPPED;

   assign mem.mem_ready = (state == RESP);
   assign mem.mem_rdata = (state == RESP && is_read) ? rd_val
                        : (RDATA_HOLD ? rdata_hold : 32'h0);

   // Gated by mem_valid so an aborting core never hands a byte to the sink.
   assign cons_valid = (state == CONS) && mem.mem_valid;
   assign cons_data  = wdata_q[7:0];

   logic unused_bits;
   assign unused_bits = ^{mem.mem_instr, off[1:0], off[31:IDX_W+2]};

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Bench for picorv32_mem_responder: three configurations share one stimulus
// bus; a select picks which instance sees mem_valid.
module tb_picorv32_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0, instr = 1'b0, cons_ready = 1'b1;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   int          sel = 0;

   logic [2:0]        rdy_v, cv_v, err_v;
   logic [2:0][31:0]  rd_v, ea_v;
   logic [2:0][7:0]   cd_v;
   logic        rdy, cv, errf;
   logic [31:0] rdat, ea;
   logic [7:0]  cd;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int          WS    = (g == 0) ? 0 : (g == 1) ? 3 : 5;
      localparam logic [31:0] BASE  = (g == 2) ? 32'h0001_0000 : 32'h0;
      localparam int          WORDS = (g == 2) ? 1024 : 4096;
      localparam bit          HOLD  = (g != 2);
      picorv32_mem_responder_if bus();
      assign bus.mem_valid = valid && (sel == g);
      assign bus.mem_instr = instr;
      assign bus.mem_addr  = addr;
      assign bus.mem_wdata = wdata;
      assign bus.mem_wstrb = wstrb;
      assign rdy_v[g] = bus.mem_ready;
      assign rd_v[g]  = bus.mem_rdata;
      picorv32_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE),
                               .CONSOLE_ADDR(32'h1000_0000), .WAIT_STATES(WS),
                               .RDATA_HOLD(HOLD)) dut (
         .clk(clk), .reset(reset), .mem(bus),
         .cons_valid(cv_v[g]), .cons_data(cd_v[g]), .cons_ready(cons_ready),
         .err(err_v[g]), .err_addr(ea_v[g]));
   end

   always_comb begin
      rdy  = rdy_v[sel];
      rdat = rd_v[sel];
      cv   = cv_v[sel];
      cd   = cd_v[sel];
      errf = err_v[sel];
      ea   = ea_v[sel];
   end

   // ---- configuration knowledge and reference model ----
   function automatic int ws_of(int s);          return (s == 0) ? 0 : (s == 1) ? 3 : 5; endfunction
   function automatic logic [31:0] base_of(int s); return (s == 2) ? 32'h0001_0000 : 32'h0; endfunction
   function automatic logic [31:0] span_of(int s); return (s == 2) ? 32'h1000 : 32'h4000; endfunction
   function automatic bit hold_of(int s);        return s != 2; endfunction

   // 0 = RAM, 1 = console, 2 = unmapped
   function automatic int region_of(int s, logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h1000_0000) return 1;
      if (w >= base_of(s) && w < base_of(s) + span_of(s)) return 0;
      return 2;
   endfunction

   logic [31:0] ref_mem [int];
   logic        exp_err [3];
   logic [31:0] exp_ea [3];
   logic [31:0] last_rd [3];

   function automatic int key_of(int s, logic [31:0] a);
      return s * (1 << 20) + int'((({a[31:2], 2'b00}) - base_of(s)) >> 2);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         exp_err[s] = 1'b0; exp_ea[s] = 32'h0; last_rd[s] = 32'h0;
      end
   endtask

   task automatic model_error(input int s, input logic [31:0] a);
      if (!exp_err[s]) begin exp_err[s] = 1'b1; exp_ea[s] = a; end
   endtask

   task automatic model_access(input int s, input logic [31:0] a, d, input logic [3:0] st,
                               output logic [31:0] exp);
      int r, k;
      logic [31:0] w;
      r = region_of(s, a);
      exp = 32'h0;
      if (r == 0) begin
         k = key_of(s, a);
         if (st != 4'h0) begin
            w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
            for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[k] = w;
         end else begin
            exp = ref_mem[k];
         end
      end else if (r == 2) begin
         model_error(s, a);
      end
      if (st == 4'h0) last_rd[s] = exp;
   endtask

   function automatic int exp_lat(int s, logic [31:0] a, logic [3:0] st);
      return (region_of(s, a) == 1 && st != 4'h0) ? 2 : 2 + ws_of(s);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one request from a negedge; returns at the negedge after ready.
   task automatic do_req(input int s, input logic [31:0] a, d, input logic [3:0] st,
                         output logic [31:0] rd, output int lat, output int ncons,
                         output logic [7:0] cbyte);
      sel = s; addr = a; wdata = d; wstrb = st; instr = 1'($urandom); valid = 1'b1;
      lat = 0; ncons = 0; cbyte = 8'h0;
      do begin
         @(negedge clk);
         lat++;
         if (cv) begin ncons++; cbyte = cd; end
      end while (!rdy && lat < 200);
      chk("ready_seen", rdy, 1'b1);
      rd = rdat;
      valid = 1'b0; wstrb = 4'h0;
      @(negedge clk);
      chk("ready_width", rdy, 1'b0);
   endtask

   task automatic xfer(input int s, input logic [31:0] a, d, input logic [3:0] st,
                       output logic [31:0] rd, output logic [31:0] exp, output int lat,
                       output int ncons, output logic [7:0] cbyte);
      do_req(s, a, d, st, rd, lat, ncons, cbyte);
      model_access(s, a, d, st, exp);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, ex, a, d;
      logic [3:0]  st;
      logic [7:0]  cb;
      int          lat, nc, s, cls;

      tbl[0]  = '{32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'h0};
      tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_F00D};
      tbl[2]  = '{32'h0000_0010, 32'h0000_AB00, 4'h2, 32'h0};
      tbl[3]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_AB0D};
      tbl[4]  = '{32'h0000_0013, 32'h1122_3344, 4'h8, 32'h0};
      tbl[5]  = '{32'h0000_0012, 32'h0,         4'h0, 32'h11FE_AB0D};
      tbl[6]  = '{32'h0000_3FFC, 32'hDEAD_BEEF, 4'hF, 32'h0};
      tbl[7]  = '{32'h0000_3FFF, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[8]  = '{32'h1000_0003, 32'h0,         4'h0, 32'h0};
      tbl[9]  = '{32'h0000_0004, 32'hA5A5_5A5A, 4'hF, 32'h0};
      tbl[10] = '{32'h0000_0004, 32'h0,         4'h0, 32'hA5A5_5A5A};

      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy_v[0], 1'b0);
      chk("rst_rdata", rd_v[0], 32'h0);
      chk("rst_cons_valid", cv_v[0], 1'b0);
      chk("rst_cons_data", cd_v[0], 8'h0);
      chk("rst_err", err_v, 3'b000);
      chk("rst_err_addr", ea_v[0], 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // table: WAIT_STATES=0 instance
      for (int i = 0; i < 11; i++) begin
         xfer(0, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, ex, lat, nc, cb);
         chk($sformatf("tbl%0d_lat", i), lat, 2);
         if (tbl[i].wstrb == 4'h0) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end
      chk("tbl_err_clear", err_v[0], 1'b0);

      // WAIT_STATES=3 latency and partial write
      xfer(1, 32'h10, 32'hCAFE_F00D, 4'hF, rd, ex, lat, nc, cb);
      chk("ws3_wr_lat", lat, 5);
      xfer(1, 32'h10, 32'h0000_AB00, 4'h2, rd, ex, lat, nc, cb);
      xfer(1, 32'h10, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("ws3_rd_lat", lat, 5);
      chk("ws3_rdata", rd, 32'hCAFE_AB0D);

      // console write stalled by the sink for 10 cycles
      sel = 0; cons_ready = 1'b0;
      addr = 32'h1000_0000; wdata = 32'h41; wstrb = 4'hF; valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("cons_stall_valid", cv, 1'b1);
         chk("cons_stall_data", cd, 8'h41);
         chk("cons_stall_noready", rdy, 1'b0);
      end
      cons_ready = 1'b1;
      @(negedge clk);
      chk("cons_ready_after_hs", rdy, 1'b1);
      chk("cons_valid_after_hs", cv, 1'b0);
      valid = 1'b0; wstrb = 4'h0;
      @(negedge clk);
      chk("cons_ready_width", rdy, 1'b0);

      // unmapped read then write: first error sticks
      xfer(0, 32'h2000_0000, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("unmapped_rdata", rd, 32'h0);
      chk("unmapped_err", errf, 1'b1);
      xfer(0, 32'h3000_0000, 32'h1234, 4'hF, rd, ex, lat, nc, cb);
      chk("unmapped_wr_lat", lat, 2);
      chk("err_addr_first", ea, 32'h2000_0000);

      // WAIT_STATES=5: drop mem_valid mid-WAIT on a write
      xfer(2, 32'h0001_0020, 32'h1234_5678, 4'hF, rd, ex, lat, nc, cb);
      chk("ws5_lat", lat, 7);
      sel = 2; addr = 32'h0001_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; valid = 1'b1;
      repeat (3) begin @(negedge clk); chk("drop_noready_pre", rdy, 1'b0); end
      valid = 1'b0; wstrb = 4'h0;
      repeat (8) begin @(negedge clk); chk("drop_noready_post", rdy, 1'b0); end
      model_error(2, 32'h0001_0020);
      chk("drop_err", errf, 1'b1);
      chk("drop_err_addr", ea, 32'h0001_0020);
      xfer(2, 32'h0001_0020, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("drop_readback", rd, 32'h1234_5678);
      chk("nohold_idle_rdata", rdat, 32'h0);
      xfer(2, 32'h0000_FFFC, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("below_base_rdata", rd, 32'h0);
      chk("below_base_err_addr", ea, 32'h0001_0020);
      xfer(2, 32'h0001_0FFC, 32'h600D_CAFE, 4'hF, rd, ex, lat, nc, cb);
      xfer(2, 32'h0001_0FFC, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("top_word_rdata", rd, 32'h600D_CAFE);
      xfer(2, 32'h0001_1000, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("past_top_rdata", rd, 32'h0);

      // randomized traffic against the reference model
      for (int it = 0; it < 120; it++) begin
         s = $urandom_range(0, 2);
         cls = $urandom_range(0, 9);
         d = $urandom;
         st = 4'h0;
         if (cls <= 5) begin
            a = base_of(s) + 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            if (!ref_mem.exists(key_of(s, a))) st = 4'hF;
            else if ($urandom_range(0, 1) == 1) st = 4'($urandom_range(1, 15));
         end else if (cls == 6) begin
            a = 32'h4000_0000 + 32'($urandom_range(0, 4095)) * 4;
            st = 4'($urandom_range(0, 1) * 15);
         end else if (cls == 7) begin
            a = 32'h1000_0000 + 32'($urandom_range(0, 3)); st = 4'($urandom_range(1, 15));
         end else if (cls == 8) begin
            a = 32'h1000_0000;
         end else begin
            a = 32'h0000_F000 + 32'($urandom_range(0, 255)) * 4;
            st = 4'($urandom_range(0, 1) * 15);
         end
         xfer(s, a, d, st, rd, ex, lat, nc, cb);
         if (st == 4'h0) chk("rand_rdata", rd, ex);
         chk("rand_lat", lat, exp_lat(s, a, st));
         chk("rand_cons_cnt", nc, (region_of(s, a) == 1 && st != 4'h0) ? 1 : 0);
         if (region_of(s, a) == 1 && st != 4'h0) chk("rand_cons_data", cb, d[7:0]);
         chk("rand_err", errf, exp_err[s]);
         chk("rand_err_addr", ea, exp_ea[s]);
         chk("rand_rdata_idle", rdat, hold_of(s) ? last_rd[s] : 32'h0);
      end

      // reset while a console write is stalled
      sel = 0; cons_ready = 1'b0;
      addr = 32'h1000_0000; wdata = 32'h5A; wstrb = 4'hF; valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_cons_valid", cv, 1'b1);
      chk("pre_rst_err", errf, 1'b1);
      reset = 1'b1;
      #1;
      chk("async_rst_cons_valid", cv, 1'b0);
      chk("async_rst_ready", rdy, 1'b0);
      chk("async_rst_err", errf, 1'b0);
      chk("async_rst_err_addr", ea, 32'h0);
      valid = 1'b0; wstrb = 4'h0;
      model_reset();
      @(negedge clk);
      reset = 1'b0; cons_ready = 1'b1;
      @(negedge clk);
      xfer(0, 32'h10, 32'h0, 4'h0, rd, ex, lat, nc, cb);
      chk("post_rst_rdata", rd, 32'h11FE_AB0D);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_err", errf, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
